// File: rtl/perceptron_n_if.sv
// perceptron_n_if: load/readback/training handshake bundle for perceptron_n
interface perceptron_n_if #(parameter int W = 8, parameter int N = 2) ();
  logic go, update, correct;
  logic [W-1:0] in_val;
  logic [$clog2(N+2)-1:0] sel_out;
  logic [W-1:0] out_val;
  logic sync, done, classification;
  modport master (output go, update, correct, in_val, sel_out, input out_val, sync, done, classification);
  modport slave (input go, update, correct, in_val, sel_out, output out_val, sync, done, classification);
endinterface

// File: rtl/perceptron_n.sv
// perceptron_n: fixed-point N-feature perceptron with serial load, eval and training passes
// Define PERCEPTRON_SAT_EN to saturate arithmetic instead of wrapping.
module perceptron_n #(
  parameter int W = 8,
  parameter int FRAC = 4,
  parameter int N = 2,
  parameter int MAX_ITER = 3
) (
  input logic clk,
  input logic reset_l,
  perceptron_n_if.slave io
);
  localparam int CW = $clog2(N+2);
  localparam int IW = $clog2(MAX_ITER+1);
  localparam int L = 2*W+1;
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_RATE, LOAD_X, COMP, EVAL, UPD} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] iter;
  logic signed [W-1:0] w [0:N];
  logic signed [W-1:0] x [0:N-1];
  logic signed [W-1:0] rate, acc, wk, xk, term, delta, wnew, acc_nxt;
  logic cls, load, wload, pos, last, xlast, fin;

  function automatic logic signed [W-1:0] fit(input logic signed [L-1:0] v);
`ifdef PERCEPTRON_SAT_EN
    logic signed [L-1:0] vmax, vmin;
    vmax = L'((2**(W-1))-1);
    vmin = ~vmax;
    return v > vmax ? vmax[W-1:0] : v < vmin ? vmin[W-1:0] : v[W-1:0];
`else
    return v[W-1:0];
`endif
  endfunction

  function automatic logic signed [L-1:0] ext(input logic signed [W-1:0] a);
    return {{(L-W){a[W-1]}}, a};
  endfunction

  function automatic logic signed [W-1:0] mulq(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = a * b;
    p = p >>> FRAC;
    return fit({p[2*W-1], p});
  endfunction

  always_comb begin
    wk = w[0];
    xk = '0;
    for (int i = 1; i <= N; i++)
      if (cnt == CW'(i)) begin
        wk = w[i];
        xk = x[i-1];
      end
  end

  // x0 is 1.0, so the bias update step is the rate itself
  assign term = mulq(wk, xk);
  assign delta = cnt == '0 ? rate : mulq(rate, xk);
  assign wnew = io.correct ? fit(ext(wk) + ext(delta)) : fit(ext(wk) - ext(delta));
  assign acc_nxt = cnt == '0 ? wk : fit(ext(acc) + ext(term));

  assign load = state == IDLE || state == LOAD_W || state == LOAD_RATE || state == LOAD_X;
  assign wload = io.go && (state == IDLE || state == LOAD_W);
  assign pos = !acc[W-1] && |acc;
  assign last = cnt == CW'(N);
  assign xlast = cnt == CW'(N-1);
  assign fin = !io.update || (pos == io.correct) || iter == IW'(MAX_ITER);
  assign io.sync = load && io.go && reset_l;
  assign io.done = state == EVAL && fin;
  assign io.classification = cls;

  always_comb begin
    io.out_val = '0;
    for (int i = 0; i <= N; i++)
      if (io.sel_out == CW'(i)) io.out_val = w[i];
    if (io.sel_out == CW'(N+1)) io.out_val = acc;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = io.go ? LOAD_W : IDLE;
      LOAD_W:    nxt = io.go && last ? LOAD_RATE : LOAD_W;
      LOAD_RATE: nxt = io.go ? LOAD_X : LOAD_RATE;
      LOAD_X:    nxt = io.go && xlast ? COMP : LOAD_X;
      COMP:      nxt = last ? EVAL : COMP;
      EVAL:      nxt = fin ? LOAD_RATE : UPD;
      UPD:       nxt = last ? COMP : UPD;
      default:   nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      state <= IDLE;
      cnt <= '0;
      iter <= '0;
      rate <= '0;
      acc <= '0;
      cls <= 1'b0;
      for (int i = 0; i <= N; i++) w[i] <= '0;
      for (int i = 0; i < N; i++) x[i] <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE, LOAD_W: if (io.go) cnt <= last ? '0 : cnt + 1'b1;
        LOAD_RATE:    if (io.go) rate <= io.in_val;
        LOAD_X: if (io.go) begin
          cnt <= xlast ? '0 : cnt + 1'b1;
          iter <= '0;
        end
        COMP: begin
          acc <= acc_nxt;
          cnt <= last ? '0 : cnt + 1'b1;
        end
        EVAL: cls <= pos;
        UPD: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) iter <= iter + 1'b1;
        end
        default: ;
      endcase
      for (int i = 0; i <= N; i++)
        if (cnt == CW'(i) && (wload || state == UPD)) w[i] <= state == UPD ? wnew : io.in_val;
      for (int i = 0; i < N; i++)
        if (cnt == CW'(i) && state == LOAD_X && io.go) x[i] <= io.in_val;
    end
endmodule

// File: tb/tb_perceptron_n.sv
// tb_perceptron_n: directed-vector bench for perceptron_n at W=8 FRAC=4 N=2 MAX_ITER=3
module tb_perceptron_n;
  logic clk, reset_l;
  int errs, checks;
  perceptron_n_if #(.W(8), .N(2)) io ();
  perceptron_n #(.W(8), .FRAC(4), .N(2), .MAX_ITER(3)) dut (.clk(clk), .reset_l(reset_l), .io(io));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] v);
    io.go = 1;
    io.in_val = v;
    #1 check("sync", io.sync, 1);
    @(negedge clk);
    io.go = 0;
  endtask

  task automatic loadw(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a);
    send(b);
    send(c);
  endtask

  task automatic loadrx(input logic [7:0] r, input logic [7:0] a, input logic [7:0] b);
    send(r);
    send(a);
    send(b);
  endtask

  task automatic readback(input string tag, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
    io.sel_out = 0; #1 check({tag, "_w0"}, io.out_val, e0);
    io.sel_out = 1; #1 check({tag, "_w1"}, io.out_val, e1);
    io.sel_out = 2; #1 check({tag, "_w2"}, io.out_val, e2);
    io.sel_out = 3; #1 check({tag, "_acc"}, io.out_val, e3);
  endtask

  task automatic run(input string tag, input int lat);
    int c;
    c = 1;
    #1;
    while (!io.done && c < 100) begin
      if (io.go) check("sync_held", io.sync, 0);
      io.sel_out = io.sel_out + 1'b1;
      @(negedge clk);
      #1;
      c++;
    end
    io.go = 0;
    check(tag, c, lat);
    @(negedge clk);
    #1 check({tag, "_pulse"}, io.done, 0);
  endtask

  initial begin
    errs = 0;
    checks = 0;
    reset_l = 0;
    io.go = 0;
    io.update = 0;
    io.correct = 0;
    io.in_val = 0;
    io.sel_out = 0;
    repeat (2) @(negedge clk);
    #1 check("rst_done", io.done, 0);
    check("rst_sync", io.sync, 0);
    check("rst_cls", io.classification, 0);
    readback("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    reset_l = 1;

    loadw(8'h10, 8'h10, 8'hF0);
    loadrx(8'h08, 8'h10, 8'h10);
    run("lat_eval", 4);
    check("cls_eval", io.classification, 1);
    readback("eval", 8'h10, 8'h10, 8'hF0, 8'h10);

    io.update = 1;
    io.correct = 0;
    loadrx(8'h08, 8'h10, 8'h10);
    io.go = 1;
    io.in_val = 8'h55;
    run("lat_upd1", 11);
    check("cls_upd1", io.classification, 0);
    readback("upd1", 8'h08, 8'h08, 8'hE8, 8'hF8);

    io.correct = 1;
    loadrx(8'h00, 8'h10, 8'h10);
    run("lat_max", 25);
    check("cls_max", io.classification, 0);
    readback("max", 8'h08, 8'h08, 8'hE8, 8'hF8);

    reset_l = 0;
    @(negedge clk);
    reset_l = 1;
    io.update = 0;
    loadw(8'h00, 8'h7F, 8'h00);
    loadrx(8'h00, 8'h7F, 8'h00);
    run("lat_ovf", 4);
`ifdef PERCEPTRON_SAT_EN
    check("cls_ovf", io.classification, 1);
    readback("ovf", 8'h00, 8'h7F, 8'h00, 8'h7F);
`else
    check("cls_ovf", io.classification, 0);
    readback("ovf", 8'h00, 8'h7F, 8'h00, 8'hF0);
`endif

    loadrx(8'h08, 8'h10, 8'h10);
    @(negedge clk);
    reset_l = 0;
    io.go = 1;
    #1 check("mid_sync", io.sync, 0);
    check("mid_done", io.done, 0);
    check("mid_cls", io.classification, 0);
    readback("mid", 8'h00, 8'h00, 8'h00, 8'h00);
    io.go = 0;
    @(negedge clk);
    reset_l = 1;
    send(8'h22);
    send(8'h33);
    readback("reload", 8'h22, 8'h33, 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
